// File: rtl/mist_console_pkg.sv
// MiST console UART shared constants.
// Bit timing and TX state encoding shared by transmitter and receiver.
package mist_console_pkg;

  localparam int unsigned CLK_HZ_DEF = 100_000_000;
  localparam int unsigned BAUD_DEF   = 115_200;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int unsigned calc_ticks(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/mist_tx_fifo.sv
// MiST console TX byte FIFO.
// First-word-fall-through head, clocked push/pop, count-based full/empty.
module mist_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd) count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mist_console_tx.sv
// MiST console UART transmitter, 8N1.
// FIFO-buffered; back-to-back frames without idle gap.
module mist_console_tx
  import mist_console_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] par_in_data,
  input  logic       par_in_strobe,
  output logic       par_in_ready,
  output logic       ser_out,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned TICKS = calc_ticks(CLK_HZ, BAUD);
  localparam int unsigned TW    = $clog2(TICKS + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TICKS - 1);

  logic [1:0]    state;
  logic [TW-1:0] tick;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          bit_end;
  logic          pop;

  mist_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .wr_en   (par_in_strobe),
    .wr_data (par_in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign bit_end      = tick == '0;
  assign par_in_ready = !full;
  assign busy         = (state != ST_IDLE) || !empty;

  // Pop from idle, or at the end of a stop bit to chain frames.
  always_comb begin
    pop = 1'b0;
    if (!empty)
      pop = (state == ST_IDLE) ||
            (state == ST_STOP && bit_end);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      tick     <= '0;
      idx      <= '0;
      sh       <= '0;
      ser_out  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (par_in_strobe && full) overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            sh      <= head;
            ser_out <= 1'b0;
            tick    <= TMAX;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            ser_out <= sh[0];
            sh      <= sh >> 1;
            idx     <= '0;
            tick    <= TMAX;
            state   <= ST_DATA;
          end else begin
            tick <= tick - TW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            tick <= TMAX;
            if (idx == 3'd7) begin
              ser_out <= 1'b1;
              state   <= ST_STOP;
            end else begin
              ser_out <= sh[0];
              sh      <= sh >> 1;
              idx     <= idx + 3'd1;
            end
          end else begin
            tick <= tick - TW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              sh      <= head;
              ser_out <= 1'b0;
              tick    <= TMAX;
              state   <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tick <= tick - TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mist_console_tx.md
MIST_CONSOLE_TX -- requirements
Module: mist_console_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 16, transmit buffer entries (power of two, 2..256).
REQ-004 clk  input  1  system clock; one clock; all logic on rising edge.
REQ-005 n_reset  input  1  asynchronous, active-low reset.
REQ-006 par_in_data  input  8  byte to transmit, sampled when par_in_strobe=1.
REQ-007 par_in_strobe  input  1  one-cycle write request.
REQ-008 par_in_ready  output  1  1 when the FIFO is not full.
REQ-009 ser_out  output  1  serial line, idle high, registered.
REQ-010 busy  output  1  1 while a frame is on the line or the FIFO is non-empty.
REQ-011 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-012 TICKS = CLK_HZ/BAUD (integer division): 868 at the defaults; every bit lasts exactly TICKS cycles.
REQ-013 Frame is 8N1: start bit 0, data bits LSB first, one stop bit 1; 10*TICKS cycles per frame.
REQ-014 FSM states are IDLE, START, DATA, STOP.
REQ-015 IDLE with FIFO non-empty: pop the head into the shift register, drive ser_out<=0, enter START, load the bit counter.
REQ-016 START -> DATA after TICKS cycles; DATA shifts one bit every TICKS cycles, 8 bits, with a 3-bit index; DATA -> STOP after bit 7.
REQ-017 STOP drives 1 for TICKS cycles; then, if the FIFO is non-empty, start the next frame with no idle cycle, else go to IDLE.
REQ-018 Latency: a write to an empty FIFO while in IDLE at edge N makes ser_out low from edge N+1.
REQ-019 Write while full (par_in_ready=0): the byte is dropped and overflow<=1, even if a pop occurs in the same cycle.
REQ-020 Simultaneous write and pop while not full: both take effect and the occupancy is unchanged.
REQ-021 A write to an empty FIFO while the FSM is mid-frame is held until the current STOP bit completes.
REQ-022 Pointers wrap modulo FIFO_DEPTH; the count is width clog2(FIFO_DEPTH)+1, so full and empty are unambiguous.
REQ-023 par_in_ready and busy derive from registered state only; there is no combinational path from par_in_strobe.

Reset
REQ-024 n_reset low immediately forces ser_out=1, state=IDLE, FIFO empty, par_in_ready=1, busy=0, overflow=0, counters=0.
REQ-025 Reset mid-frame aborts the frame without completing it; the line stays high until new data is written after release.
REQ-026 After release, the first transmit needs a write; no spurious start bit.

Structure
REQ-027 Shared package mist_console_pkg holds the default CLK_HZ and BAUD constants, the TICKS calculation, and the FSM state encoding; the receiver uses the same TICKS.
REQ-028 The FIFO is a separate sub-module, mist_tx_fifo (synchronous read/write, full/empty/count outputs, async active-low reset).
REQ-029 The bit timer, FSM and shift register reside in mist_console_tx.

Verification
REQ-030 Write 0x55 at default parameters -> ser_out = 0,1,0,1,0,1,0,1,0,1, each level held 868 cycles; busy falls after 8680 cycles.
REQ-031 Back-to-back writes 0xA5 then 0x3C -> two contiguous frames, 17360 cycles total, no idle gap; bits 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1.
REQ-032 17 writes in 17 consecutive cycles with FIFO_DEPTH=16 -> first byte pops at cycle 1, remaining 16 fill the FIFO, overflow=0; an 18th write -> dropped, overflow=1, par_in_ready=0.
REQ-033 Assert n_reset low at cycle 3000 of the 0xFF frame -> ser_out=1 within the same cycle, busy=0, FIFO empty; a following 0x0D write transmits correctly.
REQ-034 Loopback into the existing mist_console receiver with bytes 0x00, 0xFF, 0x0D, 0x80 -> receiver strobes once per byte with matching data.
REQ-035 Repeat REQ-030 with CLK_HZ=1000000, BAUD=100000 (TICKS=10) -> 10-cycle bit cells.
